// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage types: bubble word, XLEN, fetch FSM encoding and the IF/ID payload.
package fetch_unit_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INS = 32'h0000_0013;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] ins;
    logic            valid;
  } ifid_t;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: one-cycle capture of pc/ins; flush inserts a bubble.
// hold freezes the contents; flush has priority over hold.
module if_id_reg
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_VAL = NOP_INS
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            hold,
  input  logic            flush,
  input  logic [XLEN-1:0] pc_d,
  input  logic [XLEN-1:0] ins_d,
  output ifid_t           q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '{pc: '0, ins: NOP_VAL, valid: 1'b0};
    end else if (flush) begin
      q <= '{pc: pc_d, ins: NOP_VAL, valid: 1'b0};
    end else if (!hold) begin
      q <= '{pc: pc_d, ins: ins_d, valid: 1'b1};
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC register, RUN/HALT FSM and IF/ID stage; fetch latency is one cycle.
// stall holds PC and IF/ID; redirect flushes and reloads PC with priority over stall.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              IMEM_BYTES = 400,
  parameter logic [XLEN-1:0] NOP_INS    = fetch_unit_pkg::NOP_INS
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_data,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_ins,
  output logic            if_valid,
  output logic            halted
);

  localparam logic [XLEN-1:0] LAST_PC = XLEN'(IMEM_BYTES - 4);

  fetch_state_t    state;
  logic [XLEN-1:0] pc;
  logic            in_range;
  logic            ifid_hold;
  logic            ifid_flush;
  ifid_t           ifid_q;

  assign in_range = (pc <= LAST_PC);

  // HALT ignores stall and keeps flushing, so IF/ID never shows a valid slot there.
  assign ifid_hold  = (state == RUN) && !redirect && stall;
  assign ifid_flush = !ifid_hold && (redirect || (state == HALT) || !in_range);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      pc    <= RESET_PC;
    end else begin
      case (state)
        RUN: begin
          if (redirect) begin
            pc <= align_word(redirect_pc);
          end else if (!stall) begin
            if (in_range) begin
              pc <= pc + 32'd4;
            end else begin
              state <= HALT;
            end
          end
        end
        HALT: begin
          if (redirect) begin
            pc    <= align_word(redirect_pc);
            state <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  if_id_reg #(
    .NOP_VAL(NOP_INS)
  ) u_if_id_reg (
    .clk  (clk),
    .rst  (rst),
    .hold (ifid_hold),
    .flush(ifid_flush),
    .pc_d (pc),
    .ins_d(imem_data),
    .q    (ifid_q)
  );

  assign imem_addr = pc;
  assign if_pc     = ifid_q.pc;
  assign if_ins    = ifid_q.ins;
  assign if_valid  = ifid_q.valid;
  assign halted    = (state == HALT);

endmodule
